// File: rtl/datapath_task2b_pkg.sv
// Shared constants and FSM state encoding for the RC4 PRGA datapath.
package datapath_task2b_pkg;

    localparam int MSG_LEN_DEF = 32;
    localparam int SA_W        = 8;
    localparam int MA_W        = 5;
    localparam int D_W         = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INC_I,
        S_WAIT_SI,
        S_READ_SI,
        S_ADDR_J,
        S_WAIT_SJ,
        S_READ_SJ,
        S_WR_I,
        S_WR_J,
        S_ADDR_F,
        S_WAIT_F,
        S_READ_F,
        S_WR_D,
        S_NEXT,
        S_DONE
    } state_e;

endpackage

// File: rtl/datapath_task2b.sv
// RC4 PRGA stage: walks a key-scheduled S memory, XORs the keystream
// with ciphertext from ROM and writes plaintext to the message RAM.
module datapath_task2b
    import datapath_task2b_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEF
) (
    input  logic            clk,
    input  logic            restart,
    input  logic            commenco,
    output logic [SA_W-1:0] address,
    input  logic [D_W-1:0]  q,
    output logic [D_W-1:0]  data,
    output logic            wen,
    output logic [MA_W-1:0] address_e,
    input  logic [D_W-1:0]  q_e,
    output logic [MA_W-1:0] address_d,
    output logic [D_W-1:0]  data_d,
    output logic            wen_d,
    output logic            finito
);

    localparam logic [MA_W-1:0] K_LAST = MA_W'(MSG_LEN - 1);

    state_e          state_q;
    logic [SA_W-1:0] i_q, j_q;
    logic [MA_W-1:0] k_q;
    logic [D_W-1:0]  si_q, sj_q, f_q, e_q;
    logic [SA_W-1:0] addr_q;
    logic [D_W-1:0]  data_q;
    logic            wen_q;
    logic [MA_W-1:0] addr_e_q, addr_d_q;
    logic [D_W-1:0]  data_d_q;
    logic            wen_d_q;
    logic            finito_q;

    always_ff @(posedge clk) begin
        if (!restart) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            si_q     <= '0;
            sj_q     <= '0;
            f_q      <= '0;
            e_q      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wen_q    <= 1'b0;
            addr_e_q <= '0;
            addr_d_q <= '0;
            data_d_q <= '0;
            wen_d_q  <= 1'b0;
            finito_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    wen_q    <= 1'b0;
                    wen_d_q  <= 1'b0;
                    finito_q <= 1'b0;
                    if (commenco) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        state_q <= S_INC_I;
                    end
                end
                S_INC_I: begin
                    i_q     <= i_q + 8'd1;
                    addr_q  <= i_q + 8'd1;
                    state_q <= S_WAIT_SI;
                end
                S_WAIT_SI: state_q <= S_READ_SI;
                S_READ_SI: begin
                    si_q    <= q;
                    j_q     <= j_q + q;
                    state_q <= S_ADDR_J;
                end
                S_ADDR_J: begin
                    addr_q  <= j_q;
                    state_q <= S_WAIT_SJ;
                end
                S_WAIT_SJ: state_q <= S_READ_SJ;
                S_READ_SJ: begin
                    sj_q    <= q;
                    state_q <= S_WR_I;
                end
                S_WR_I: begin
                    addr_q  <= i_q;
                    data_q  <= sj_q;
                    wen_q   <= 1'b1;
                    state_q <= S_WR_J;
                end
                S_WR_J: begin
                    addr_q  <= j_q;
                    data_q  <= si_q;
                    wen_q   <= 1'b1;
                    state_q <= S_ADDR_F;
                end
                // Swap is committed by now, so S[si+sj] reads the new S
                S_ADDR_F: begin
                    wen_q    <= 1'b0;
                    addr_q   <= si_q + sj_q;
                    addr_e_q <= k_q;
                    state_q  <= S_WAIT_F;
                end
                S_WAIT_F: state_q <= S_READ_F;
                S_READ_F: begin
                    f_q     <= q;
                    e_q     <= q_e;
                    state_q <= S_WR_D;
                end
                S_WR_D: begin
                    addr_d_q <= k_q;
                    data_d_q <= f_q ^ e_q;
                    wen_d_q  <= 1'b1;
                    state_q  <= S_NEXT;
                end
                S_NEXT: begin
                    wen_d_q <= 1'b0;
                    if (k_q == K_LAST) begin
                        finito_q <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        k_q     <= k_q + 5'd1;
                        state_q <= S_INC_I;
                    end
                end
                S_DONE: finito_q <= 1'b1;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign address   = addr_q;
    assign data      = data_q;
    assign wen       = wen_q;
    assign address_e = addr_e_q;
    assign address_d = addr_d_q;
    assign data_d    = data_d_q;
    assign wen_d     = wen_d_q;
    assign finito    = finito_q;

endmodule

// File: tb/tb_datapath_task2b.sv
// Directed bench for the RC4 PRGA datapath with behavioural memories
// and a reference-model scoreboard of decrypted bytes.
module tb_datapath_task2b;

    logic       clk = 1'b0;
    logic       restart;
    logic       commenco;
    logic [7:0] address;
    logic [7:0] q;
    logic [7:0] data;
    logic       wen;
    logic [4:0] address_e;
    logic [7:0] q_e;
    logic [4:0] address_d;
    logic [7:0] data_d;
    logic       wen_d;
    logic       finito;

    datapath_task2b dut (
        .clk      (clk),
        .restart  (restart),
        .commenco (commenco),
        .address  (address),
        .q        (q),
        .data     (data),
        .wen      (wen),
        .address_e(address_e),
        .q_e      (q_e),
        .address_d(address_d),
        .data_d   (data_d),
        .wen_d    (wen_d),
        .finito   (finito)
    );

    always #5 clk = ~clk;

    logic [7:0]  smem [256];
    logic [7:0]  emem [32];
    logic [7:0]  dmem [32];
    logic        init_req = 1'b0;
    logic        init_ident = 1'b0;
    logic [12:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          dpulses = 0;

    // Synchronous memories: one-cycle registered read, write on wen
    always @(posedge clk) begin
        if (init_req) begin
            for (int x = 0; x < 256; x++)
                smem[x] <= init_ident ? 8'(x) : 8'h00;
            for (int x = 0; x < 32; x++)
                dmem[x] <= 8'h00;
        end else begin
            if (wen) smem[address] <= data;
            if (wen_d) dmem[address_d] <= data_d;
        end
        q   <= smem[address];
        q_e <= emem[address_e];
    end

    always @(negedge clk) begin
        if (wen_d) dpulses++;
        if (wen || wen_d) begin
            checks++;
            assert (!(wen && wen_d)) else begin
                errors++;
                $error("FAIL wen_overlap observed 1 expected 0");
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_address"}, 32'(address), 0);
        chk({tag, "_data"}, 32'(data), 0);
        chk({tag, "_wen"}, 32'(wen), 0);
        chk({tag, "_address_e"}, 32'(address_e), 0);
        chk({tag, "_address_d"}, 32'(address_d), 0);
        chk({tag, "_data_d"}, 32'(data_d), 0);
        chk({tag, "_wen_d"}, 32'(wen_d), 0);
        chk({tag, "_finito"}, 32'(finito), 0);
    endtask

    task automatic load_mem(input bit ident, input logic [7:0] ev);
        for (int x = 0; x < 32; x++) emem[x] = ev;
        @(negedge clk);
        init_ident = ident;
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        @(negedge clk);
    endtask

    // Reference RC4 PRGA over the current S image and E contents
    task automatic build_model(input int n);
        logic [7:0] s [256];
        logic [7:0] i, j, t, f;
        for (int x = 0; x < 256; x++) s[x] = smem[x];
        i = 0;
        j = 0;
        for (int k = 0; k < n; k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i];
            s[i] = s[j];
            s[j] = t;
            t = s[i] + s[j];
            f = s[t];
            exp_q.push_back({5'(k), f ^ emem[k]});
        end
    endtask

    task automatic start_op(input int cycles);
        commenco = 1'b1;
        repeat (cycles) @(negedge clk);
        commenco = 1'b0;
    endtask

    task automatic do_reset();
        restart = 1'b0;
        @(negedge clk);
        restart = 1'b1;
        exp_q.delete();
    endtask

    task automatic expect_byte(input string tag);
        bit got;
        logic [12:0] e;
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (wen_d) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s_timeout observed 0 expected 1", tag);
        end
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_addr_d"}, 32'(address_d), 32'(e[12:8]));
            chk({tag, "_data_d"}, 32'(data_d), 32'(e[7:0]));
            @(negedge clk);
            chk({tag, "_wen_d_fall"}, 32'(wen_d), 0);
        end
    endtask

    task automatic wait_addr_nz(input string tag, input logic [7:0] exp);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (address != 8'h00) begin
                got = 1'b1;
                break;
            end
        end
        chk(tag, 32'(address), 32'(exp));
    endtask

    task automatic wait_wen(input string tag);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (wen) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_seen"}, 32'(got), 1);
    endtask

    initial begin
        bit got;
        restart = 1'b0;
        commenco = 1'b0;
        for (int x = 0; x < 32; x++) emem[x] = 8'h00;
        repeat (5) @(negedge clk);
        chk_zero_outputs("reset");
        restart = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero_outputs("idle");

        // Zero memories: all indices stay 0 apart from i
        load_mem(1'b0, 8'h00);
        build_model(2);
        start_op(2);
        wait_addr_nz("z_first_read", 8'h01);
        wait_wen("z_wr_i");
        chk("z_wr_i_addr", 32'(address), 1);
        chk("z_wr_i_data", 32'(data), 0);
        @(negedge clk);
        chk("z_wr_j_addr", 32'(address), 0);
        chk("z_wr_j_wen", 32'(wen), 1);
        expect_byte("z0");
        wait_addr_nz("z_second_read", 8'h02);
        expect_byte("z1");
        do_reset();

        // Identity S, zero ciphertext, full message
        load_mem(1'b1, 8'h00);
        build_model(32);
        dpulses = 0;
        start_op(1);
        for (int k = 0; k < 32; k++) begin
            expect_byte($sformatf("id%0d", k));
            if (k == 1) begin
                chk("id_swap_s2", 32'(smem[2]), 3);
                chk("id_swap_s3", 32'(smem[3]), 2);
            end
        end
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (finito) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("id_finito", 32'(finito), 1);
        chk("id_pulses", 32'(dpulses), 32);
        chk("id_d0", 32'(dmem[0]), 32'h02);
        chk("id_d1", 32'(dmem[1]), 32'h05);
        chk("id_d2", 32'(dmem[2]), 32'h07);
        start_op(3);
        repeat (5) @(negedge clk);
        chk("id_finito_hold", 32'(finito), 1);
        chk("id_done_addr_d", 32'(address_d), 31);
        chk("id_done_wen_d", 32'(wen_d), 0);
        chk("id_done_pulses", 32'(dpulses), 32);
        do_reset();
        chk("id_finito_clr", 32'(finito), 0);

        // Identity S, ciphertext 0xFF, reset during byte 5
        load_mem(1'b1, 8'hFF);
        build_model(32);
        start_op(1);
        for (int k = 0; k < 5; k++)
            expect_byte($sformatf("ff%0d", k));
        chk("ff_d0", 32'(dmem[0]), 32'hFD);
        chk("ff_d1", 32'(dmem[1]), 32'hFA);
        repeat (6) @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
        chk_zero_outputs("midrst");
        restart = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("midrst_idle_addr", 32'(address), 0);

        // Restart from a fresh S image reproduces the first byte
        load_mem(1'b1, 8'hFF);
        build_model(1);
        start_op(1);
        expect_byte("rs0");
        @(negedge clk);
        chk("rs_d0", 32'(dmem[0]), 32'hFD);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
